// File: rtl/rp_enum_sequencer.sv
// Root-port endpoint bring-up: read Vendor/Device ID (with retry), program and
// verify BAR0, then enable memory space and bus mastering over the init_ram bus.
module rp_enum_sequencer #(
    parameter logic [31:0] CFG_BASE       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RETRY_MAX      = 8,
    parameter int unsigned RETRY_DELAY    = 4096
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        start,
    input  logic [31:0] bar0_addr,
    output logic        init_ram_req,
    output logic        init_ram_wren,
    output logic        init_ram_rden,
    output logic [31:0] init_ram_addr,
    output logic [31:0] init_ram_wdata,
    output logic [3:0]  init_ram_wbe,
    input  logic        init_ram_rdy,
    input  logic [31:0] init_ram_rdata,
    input  logic [3:0]  init_ram_rbe,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] vendor_id,
    output logic [15:0] device_id
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] DLY_LAST = 32'(RETRY_DELAY - 1);
    localparam logic [7:0]  RTY_LAST = 8'(RETRY_MAX);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID_REQ,
        S_ID_WAIT,
        S_RETRY_WAIT,
        S_BAR_WR,
        S_BAR_RD_REQ,
        S_BAR_RD_WAIT,
        S_CMD_WR,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [7:0]  r_retry;
    logic [7:0]  w_retry_nxt;
    logic [1:0]  r_err_code;
    logic [1:0]  w_err_nxt;
    logic [31:0] r_bar;
    logic        r_req;
    logic        r_wren;
    logic        r_rden;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wbe;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_vendor;
    logic [15:0] r_device;

    logic        w_hs;
    logic        w_resp;
    logic        w_start_ok;
    logic        w_id_ok;
    logic        w_is_req;
    logic        w_pl_wren;
    logic        w_pl_rden;
    logic [31:0] w_pl_addr;
    logic [31:0] w_pl_wdata;
    logic [3:0]  w_pl_wbe;

    assign w_hs       = r_req & init_ram_rdy;
    assign w_resp     = (init_ram_rbe != 4'h0);
    assign w_start_ok = start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
    assign w_id_ok    = (r_state == S_ID_WAIT) && w_resp && (init_ram_rdata[15:0] != 16'hFFFF);

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err_code;
        w_retry_nxt = r_retry;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_nxt = S_ID_REQ;
                    w_err_nxt   = 2'd0;
                    w_retry_nxt = 8'd0;
                end
            end
            S_ID_REQ: if (w_hs) w_state_nxt = S_ID_WAIT;
            S_ID_WAIT: begin
                // A response landing on the expiry cycle takes priority over the timeout.
                if (w_resp) begin
                    if (init_ram_rdata[15:0] == 16'hFFFF) begin
                        w_retry_nxt = r_retry + 8'd1;
                        if (w_retry_nxt == RTY_LAST) begin
                            w_state_nxt = S_ERROR;
                            w_err_nxt   = 2'd3;
                        end else begin
                            w_state_nxt = S_RETRY_WAIT;
                        end
                    end else begin
                        w_state_nxt = S_BAR_WR;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = 2'd1;
                end
            end
            S_RETRY_WAIT: if (r_cnt == DLY_LAST) w_state_nxt = S_ID_REQ;
            S_BAR_WR:     if (w_hs) w_state_nxt = S_BAR_RD_REQ;
            S_BAR_RD_REQ: if (w_hs) w_state_nxt = S_BAR_RD_WAIT;
            S_BAR_RD_WAIT: begin
                if (w_resp) begin
                    if (init_ram_rdata[31:4] == r_bar[31:4]) begin
                        w_state_nxt = S_CMD_WR;
                    end else begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 2'd2;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = S_ERROR;
                    w_err_nxt   = 2'd1;
                end
            end
            S_CMD_WR: if (w_hs) w_state_nxt = S_DONE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_is_req   = 1'b0;
        w_pl_wren  = 1'b0;
        w_pl_rden  = 1'b0;
        w_pl_addr  = 32'd0;
        w_pl_wdata = 32'd0;
        w_pl_wbe   = 4'h0;
        case (r_state)
            S_ID_REQ: begin
                w_is_req  = 1'b1;
                w_pl_rden = 1'b1;
                w_pl_addr = CFG_BASE | 32'd0;
            end
            S_BAR_WR: begin
                w_is_req   = 1'b1;
                w_pl_wren  = 1'b1;
                w_pl_addr  = CFG_BASE | 32'd4;
                w_pl_wdata = r_bar;
                w_pl_wbe   = 4'hF;
            end
            S_BAR_RD_REQ: begin
                w_is_req  = 1'b1;
                w_pl_rden = 1'b1;
                w_pl_addr = CFG_BASE | 32'd4;
            end
            S_CMD_WR: begin
                w_is_req   = 1'b1;
                w_pl_wren  = 1'b1;
                w_pl_addr  = CFG_BASE | 32'd1;
                w_pl_wdata = 32'h0000_0006;
                w_pl_wbe   = 4'b0011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 32'd0;
            r_retry    <= 8'd0;
            r_err_code <= 2'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // One counter serves both the response timeout and the retry delay.
            r_cnt      <= (w_state_nxt != r_state) ? 32'd0 : r_cnt + 32'd1;
            r_retry    <= w_retry_nxt;
            r_err_code <= w_err_nxt;
            r_done     <= (w_state_nxt == S_DONE);
            r_error    <= (w_state_nxt == S_ERROR);
        end
    end

    // Request is dropped on the handshake edge, so every request is followed by an idle cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_req   <= 1'b0;
            r_wren  <= 1'b0;
            r_rden  <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wbe   <= 4'h0;
        end else if (w_is_req && !w_hs) begin
            r_req   <= 1'b1;
            r_wren  <= w_pl_wren;
            r_rden  <= w_pl_rden;
            r_addr  <= w_pl_addr;
            r_wdata <= w_pl_wdata;
            r_wbe   <= w_pl_wbe;
        end else begin
            r_req   <= 1'b0;
            r_wren  <= 1'b0;
            r_rden  <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wbe   <= 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_vendor <= 16'd0;
            r_device <= 16'd0;
        end else if (w_id_ok) begin
            r_vendor <= init_ram_rdata[15:0];
            r_device <= init_ram_rdata[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_ok) r_bar <= bar0_addr & 32'hFFFF_FFF0;
    end

    assign init_ram_req   = r_req;
    assign init_ram_wren  = r_wren;
    assign init_ram_rden  = r_rden;
    assign init_ram_addr  = r_addr;
    assign init_ram_wdata = r_wdata;
    assign init_ram_wbe   = r_wbe;
    assign busy           = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
    assign done           = r_done;
    assign error          = r_error;
    assign err_code       = r_err_code;
    assign vendor_id      = r_vendor;
    assign device_id      = r_device;

endmodule

// File: tb/tb_rp_enum_sequencer.sv
// Scoreboard bench for rp_enum_sequencer: a config-space responder answers
// requests while expected handshakes are queued per scenario.
module tb_rp_enum_sequencer;

    localparam int TB_TMO   = 40;
    localparam int TB_DELAY = 50;
    localparam int TB_RETRY = 8;

    logic        clk;
    logic        srst;
    logic        start;
    logic [31:0] bar0_addr;
    logic        init_ram_req;
    logic        init_ram_wren;
    logic        init_ram_rden;
    logic [31:0] init_ram_addr;
    logic [31:0] init_ram_wdata;
    logic [3:0]  init_ram_wbe;
    logic        init_ram_rdy;
    logic [31:0] init_ram_rdata;
    logic [3:0]  init_ram_rbe;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] vendor_id;
    logic [15:0] device_id;

    rp_enum_sequencer #(
        .CFG_BASE      (32'h0000_0000),
        .TIMEOUT_CYCLES(TB_TMO),
        .RETRY_MAX     (TB_RETRY),
        .RETRY_DELAY   (TB_DELAY)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .start         (start),
        .bar0_addr     (bar0_addr),
        .init_ram_req  (init_ram_req),
        .init_ram_wren (init_ram_wren),
        .init_ram_rden (init_ram_rden),
        .init_ram_addr (init_ram_addr),
        .init_ram_wdata(init_ram_wdata),
        .init_ram_wbe  (init_ram_wbe),
        .init_ram_rdy  (init_ram_rdy),
        .init_ram_rdata(init_ram_rdata),
        .init_ram_rbe  (init_ram_rbe),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .vendor_id     (vendor_id),
        .device_id     (device_id)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [127:0] sb[$];
    logic [31:0]  id_q[$];
    int           stall_n;
    logic         no_bar_resp;
    logic [31:0]  bar_rb;
    logic         inject;
    logic [31:0]  inject_val;
    logic         id_seen;
    int           last_id_cyc;
    int           last_rd_cyc;
    logic         rd4_hs;

    logic [127:0] r_cur;
    logic [127:0] r_snap;
    logic [127:0] r_exp;
    int           wait_n;
    logic         hs_prev;
    logic         resp_pending;
    logic [31:0]  resp_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] tx(input logic wr, input logic rd, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] be);
        return {58'd0, wr, rd, a, d, be};
    endfunction

    function automatic logic [127:0] outs();
        return {20'd0, init_ram_req, init_ram_wren, init_ram_rden, init_ram_addr,
                init_ram_wdata, init_ram_wbe, busy, done, error, err_code, vendor_id, device_id};
    endfunction

    task automatic kick(input logic [31:0] bar);
        @(negedge clk);
        bar0_addr = bar;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_end(input int maxc, output int n);
        n = 0;
        while (!(done || error) && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic push_nominal(input logic [31:0] bar);
        sb.push_back(tx(1'b0, 1'b1, 32'd0, 32'd0, 4'h0));
        sb.push_back(tx(1'b1, 1'b0, 32'd4, bar, 4'hF));
        sb.push_back(tx(1'b0, 1'b1, 32'd4, 32'd0, 4'h0));
        sb.push_back(tx(1'b1, 1'b0, 32'd1, 32'h0000_0006, 4'b0011));
    endtask

    // Config-space responder: applies backpressure, answers reads one cycle after the handshake.
    initial begin
        init_ram_rdy   = 1'b1;
        init_ram_rbe   = 4'h0;
        init_ram_rdata = 32'd0;
        wait_n         = 0;
        hs_prev        = 1'b0;
        resp_pending   = 1'b0;
        resp_val       = 32'd0;
        forever begin
            @(negedge clk);
            init_ram_rbe   = 4'h0;
            init_ram_rdata = 32'd0;
            if (resp_pending) begin
                init_ram_rdata = resp_val;
                init_ram_rbe   = 4'hF;
                resp_pending   = 1'b0;
            end else if (inject) begin
                init_ram_rdata = inject_val;
                init_ram_rbe   = 4'hF;
                inject         = 1'b0;
            end
            if (hs_prev) begin
                check_eq("req_drop_after_hs", init_ram_req, 0);
                hs_prev = 1'b0;
            end
            if (init_ram_req === 1'b1) begin
                r_cur = {58'd0, init_ram_wren, init_ram_rden, init_ram_addr, init_ram_wdata, init_ram_wbe};
                if (wait_n == 0) r_snap = r_cur;
                else check_eq("stall_payload_hold", r_cur, r_snap);
                if (wait_n < stall_n) begin
                    init_ram_rdy = 1'b0;
                    wait_n++;
                end else begin
                    init_ram_rdy = 1'b1;
                    wait_n       = 0;
                    hs_prev      = 1'b1;
                    if (sb.size() == 0) begin
                        check_eq("unexpected_hs_payload", r_cur, 0);
                    end else begin
                        r_exp = sb.pop_front();
                        check_eq("hs_payload", r_cur, r_exp);
                    end
                    if (init_ram_rden && init_ram_addr == 32'd0) begin
                        if (id_seen) check_eq("id_retry_gap", 128'((cyc + 1 - last_id_cyc) >= TB_DELAY), 1);
                        id_seen      = 1'b1;
                        last_id_cyc  = cyc + 1;
                        resp_val     = (id_q.size() > 0) ? id_q.pop_front() : 32'h0953_8086;
                        resp_pending = 1'b1;
                    end else if (init_ram_rden) begin
                        last_rd_cyc = cyc + 1;
                        rd4_hs      = 1'b1;
                        if (!no_bar_resp) begin
                            resp_val     = bar_rb;
                            resp_pending = 1'b1;
                        end
                    end
                end
            end else begin
                init_ram_rdy = (stall_n == 0);
                wait_n       = 0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        srst        = 1'b1;
        start       = 1'b0;
        bar0_addr   = 32'd0;
        stall_n     = 0;
        no_bar_resp = 1'b0;
        bar_rb      = 32'd0;
        inject      = 1'b0;
        inject_val  = 32'd0;
        id_seen     = 1'b0;
        last_id_cyc = 0;
        last_rd_cyc = 0;
        rd4_hs      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", outs(), 0);
        srst = 1'b0;
        @(negedge clk);
        check_eq("idle_outputs", outs(), 0);

        // Nominal bring-up
        push_nominal(32'hE000_0000);
        id_q.push_back(32'h0953_8086);
        bar_rb = 32'hE000_0008;
        kick(32'hE000_000C);
        wait_end(40, n);
        check_eq("nom_latency_le12", 128'(n <= 12), 1);
        check_eq("nom_done_error", {done, error, err_code}, 4'b1000);
        check_eq("nom_ids", {vendor_id, device_id}, {16'h8086, 16'h0953});
        check_eq("nom_hs_left", sb.size(), 0);
        check_eq("nom_busy", busy, 0);

        // Two 0xFFFF answers, then success
        id_seen = 1'b0;
        repeat (3) sb.push_back(tx(1'b0, 1'b1, 32'd0, 32'd0, 4'h0));
        sb.push_back(tx(1'b1, 1'b0, 32'd4, 32'h1234_5670, 4'hF));
        sb.push_back(tx(1'b0, 1'b1, 32'd4, 32'd0, 4'h0));
        sb.push_back(tx(1'b1, 1'b0, 32'd1, 32'h0000_0006, 4'b0011));
        id_q.push_back(32'hFFFF_FFFF);
        id_q.push_back(32'hFFFF_FFFF);
        id_q.push_back(32'h1AB4_10EC);
        bar_rb = 32'h1234_5670;
        kick(32'h1234_5678);
        wait_end(1000, n);
        check_eq("retry_done_error", {done, error, err_code}, 4'b1000);
        check_eq("retry_ids", {vendor_id, device_id}, {16'h10EC, 16'h1AB4});
        check_eq("retry_hs_left", sb.size(), 0);

        // Retries exhausted
        id_seen = 1'b0;
        for (int i = 0; i < TB_RETRY; i++) begin
            sb.push_back(tx(1'b0, 1'b1, 32'd0, 32'd0, 4'h0));
            id_q.push_back(32'h0000_FFFF);
        end
        kick(32'h8000_0000);
        wait_end(1000, n);
        check_eq("exhaust_flags", {done, error, err_code}, 4'b0111);
        check_eq("exhaust_hs_left", sb.size(), 0);
        repeat (5) @(negedge clk);
        check_eq("exhaust_quiet", {busy, init_ram_req}, 0);

        // BAR readback never answered
        id_seen     = 1'b0;
        no_bar_resp = 1'b1;
        sb.push_back(tx(1'b0, 1'b1, 32'd0, 32'd0, 4'h0));
        sb.push_back(tx(1'b1, 1'b0, 32'd4, 32'hC000_0000, 4'hF));
        sb.push_back(tx(1'b0, 1'b1, 32'd4, 32'd0, 4'h0));
        id_q.push_back(32'h0953_8086);
        kick(32'hC000_0000);
        wait_end(500, n);
        check_eq("tmo_flags", {done, error, err_code}, 4'b0101);
        check_eq("tmo_wait_cycles", cyc - last_rd_cyc, TB_TMO);
        check_eq("tmo_hs_left", sb.size(), 0);
        inject_val = 32'hC000_0000;
        inject     = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("tmo_late_resp_ignored", {done, error, err_code, busy, init_ram_req}, 6'b010100);

        // Restart after error
        no_bar_resp = 1'b0;
        id_seen     = 1'b0;
        push_nominal(32'hA000_0000);
        id_q.push_back(32'h0953_8086);
        bar_rb = 32'hA000_0000;
        kick(32'hA000_0000);
        check_eq("restart_clears", {busy, done, error, err_code}, 5'b10000);
        wait_end(100, n);
        check_eq("restart_done", {done, error, err_code}, 4'b1000);
        check_eq("restart_hs_left", sb.size(), 0);

        // Backpressure with BAR readback mismatch
        id_seen = 1'b0;
        stall_n = 5;
        sb.push_back(tx(1'b0, 1'b1, 32'd0, 32'd0, 4'h0));
        sb.push_back(tx(1'b1, 1'b0, 32'd4, 32'hE000_0000, 4'hF));
        sb.push_back(tx(1'b0, 1'b1, 32'd4, 32'd0, 4'h0));
        id_q.push_back(32'h0953_8086);
        bar_rb = 32'hF000_0000;
        kick(32'hE000_0000);
        wait_end(500, n);
        check_eq("mismatch_flags", {done, error, err_code}, 4'b0110);
        check_eq("mismatch_hs_left", sb.size(), 0);
        stall_n = 0;
        @(negedge clk);

        // srst while waiting for BAR readback
        id_seen     = 1'b0;
        no_bar_resp = 1'b1;
        rd4_hs      = 1'b0;
        sb.push_back(tx(1'b0, 1'b1, 32'd0, 32'd0, 4'h0));
        sb.push_back(tx(1'b1, 1'b0, 32'd4, 32'h9000_0000, 4'hF));
        sb.push_back(tx(1'b0, 1'b1, 32'd4, 32'd0, 4'h0));
        id_q.push_back(32'h0953_8086);
        kick(32'h9000_0000);
        n = 0;
        while (!rd4_hs && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("srst_pre_busy", {busy, error, done}, 3'b100);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check_eq("srst_all_zero", outs(), 0);
        inject_val = 32'h9000_0000;
        inject     = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("srst_late_resp_ignored", outs(), 0);
        check_eq("srst_hs_left", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rp_enum_sequencer.md
# rp_enum_sequencer

Root-port endpoint bring-up sequencer. Sits directly upstream of the root-port requester interface and drives its 32-bit init_ram flow bus as master. After `start`, it performs the following steps:

- reads the endpoint Vendor/Device ID through configuration space, retrying while the endpoint answers 0xFFFF;
- programs BAR0 and reads it back;
- enables memory space and bus mastering in the Command register.

It then reports `done` or a coded error to the NVMe init controller.

## Interface
Reset is synchronous and active-high; the design uses a single clock.

Parameters:
- CFG_BASE, 32'h0000_0000, OR-ed with the config dword index to form `init_ram_addr` (index 0 = ID, 1 = Command, 4 = BAR0).
- TIMEOUT_CYCLES, 1024, maximum wait for read data after the request handshake.
- RETRY_MAX, 8, maximum ID reads that return 0xFFFF before failing.
- RETRY_DELAY, 4096, idle cycles between ID retries.

Ports:
- clk, in, 1, sole clock.
- srst, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle pulse; sampled only in IDLE, DONE or ERROR.
- bar0_addr, in, 32, BAR0 base; captured on an accepted `start`.
- init_ram_req, out, 1, request valid.
- init_ram_wren, out, 1, write strobe.
- init_ram_rden, out, 1, read strobe.
- init_ram_addr, out, 32, target address.
- init_ram_wdata, out, 32, write data.
- init_ram_wbe, out, 4, write byte enables.
- init_ram_rdy, in, 1, request accepted when high together with `init_ram_req`.
- init_ram_rdata, in, 32, read data.
- init_ram_rbe, in, 4, non-zero marks the cycle in which `init_ram_rdata` is valid.
- busy, out, 1, high when the state is neither IDLE, DONE nor ERROR.
- done, out, 1, sticky success flag.
- error, out, 1, sticky failure flag.
- err_code, out, 2, failure cause: 1 = timeout, 2 = BAR readback mismatch, 3 = retries exhausted.
- vendor_id, out, 16, captured from `rdata[15:0]` of the ID read.
- device_id, out, 16, captured from `rdata[31:16]` of the ID read.

## Operation
States: IDLE, ID_REQ, ID_WAIT, RETRY_WAIT, BAR_WR, BAR_RD_REQ, BAR_RD_WAIT, CMD_WR, DONE, ERROR.

- **IDLE/DONE/ERROR + start → ID_REQ.**
  - Clears `done`, `error`, `err_code` and the retry count.
  - Latches `bar0_addr & 32'hFFFF_FFF0`.
- **ID_REQ:**
  - Drives `rden=1`, `wren=0`, `addr=CFG_BASE|0`, `wbe=0`, `wdata=0`.
  - On handshake → ID_WAIT; the timeout counter clears.
- **ID_WAIT, first cycle with `rbe≠0`:**
  - If `rdata[15:0]==16'hFFFF`: increment the retry count. If the count now equals RETRY_MAX → ERROR with code 3; otherwise → RETRY_WAIT.
  - Else: capture `vendor_id`/`device_id` → BAR_WR.
- **RETRY_WAIT:** counts RETRY_DELAY cycles → ID_REQ.
- **BAR_WR:**
  - Drives `wren=1`, `addr=CFG_BASE|4`, `wdata=`latched BAR, `wbe=4'hF`.
  - On handshake → BAR_RD_REQ. Writes are posted; no response is awaited.
- **BAR_RD_REQ:** read of `CFG_BASE|4`; on handshake → BAR_RD_WAIT.
- **BAR_RD_WAIT, response:**
  - If `rdata[31:4]` equals the latched BAR `[31:4]` → CMD_WR.
  - Otherwise → ERROR with code 2.
- **CMD_WR:**
  - Drives `wren=1`, `addr=CFG_BASE|1`, `wdata=32'h0000_0006`, `wbe=4'b0011`.
  - On handshake → DONE.
- **Any WAIT state with the timeout counter reaching TIMEOUT_CYCLES-1 and no response → ERROR with code 1.**
  - A response arriving in the same cycle as expiry wins: it is processed and no error is raised.
- **Stray responses:** `rbe≠0` outside a WAIT state is ignored.
- **`start` while busy:** ignored.
- **DONE/ERROR:** `done`/`error` stay high until the next accepted `start` or `srst`.

## Timing
- **srst:** on the next edge the state is IDLE and every output is 0, including `vendor_id`/`device_id` and `err_code`. srst mid-transaction drops `req` immediately; later responses are ignored.
- **Request output:** all request outputs are registered. `start` at edge N → `init_ram_req=1` after edge N+1.
- **Request hold:** `req` and its payload are held stable until the cycle where `req&rdy`; `req` is low in the following cycle.
- **Back-to-back issue:** a new request is issued no earlier than one cycle after the previous handshake.
- **Response to next request:** response seen at edge M → next `req` high after edge M+1.
- **Timeout counter:** starts at 0 in the first WAIT cycle. `rdy` low forever in a REQ state never times out.
- **Minimum bring-up, with `rdy` always high and 1-cycle read latency:** DONE is reached within 12 cycles of `start`. `done` rises in the cycle after the CMD_WR handshake.

## Test plan
- **Nominal bring-up:**
  - Stimulus: `start`, `bar0_addr=32'hE000_000C`, ID read returns 32'h0953_8086, `rdy` always high.
  - Required: exactly 4 handshakes with addresses 0, 4, 4, 1 in that order.
  - Required: BAR write data is 32'hE000_0000; `vendor_id=8086`, `device_id=0953`; `done=1`, `error=0`.
- **Retry then success:**
  - Stimulus: ID returns FFFF twice, then 32'h0953_8086.
  - Required: 3 ID reads, each pair separated by ≥RETRY_DELAY cycles; then `done=1`.
- **Retry exhaustion:**
  - Stimulus: ID always returns FFFF.
  - Required: 8 ID reads, then `error=1`, `err_code=3`, with no BAR write issued.
- **Timeout:**
  - Stimulus: BAR readback is never answered.
  - Required: `error=1`, `err_code=1` after exactly TIMEOUT_CYCLES wait cycles.
  - Required: a late response is ignored.
  - Required: a new `start` restarts the sequence.
- **Backpressure and mismatch:**
  - Stimulus: `rdy` held low 5 cycles per request; BAR readback returns 32'hF000_0000.
  - Required: payload stable throughout each stall; `err_code=2`.
- **srst mid-sequence:**
  - Stimulus: `srst` during BAR_RD_WAIT.
  - Required: all outputs 0 next cycle.
  - Required: a response arriving afterwards produces no state change.
